// File: rtl/axis_arb_pkg.sv
// Shared definitions for the frame-granular AXI-stream arbiter:
// FSM state encoding and an elaboration-time clog2 helper.
package axis_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_rr_select.sv
// Rotate-priority encoder: returns the first requester after ptr,
// wrapping modulo PORTS, so the port at ptr itself has lowest priority.
module axis_rr_select #(
  parameter int PORTS     = 2,
  parameter int IDX_WIDTH = 1
) (
  input  logic [PORTS-1:0]     req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 any,
  output logic [IDX_WIDTH-1:0] idx
);

  // Two constant-index passes: ports above ptr first, then ports up to and
  // including ptr. Avoids a variable modulo in the datapath.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (!any && req[i] && (IDX_WIDTH'(i) > ptr)) begin
        any = 1'b1;
        idx = IDX_WIDTH'(i);
      end
    end
    for (int i = 0; i < PORTS; i++) begin
      if (!any && req[i] && (IDX_WIDTH'(i) <= ptr)) begin
        any = 1'b1;
        idx = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one AXI-stream sink between
// PORTS sources; a grant is held from the first beat until the tlast beat.
module axis_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 1
) (
  input  logic                        clk,
  input  logic                        async_rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  output logic [PORTS-1:0]            input_axis_tready,
  input  logic [PORTS-1:0]            input_axis_tlast,
  input  logic [PORTS-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic                        output_axis_tlast,
  output logic                        output_axis_tuser,
  output logic                        grant_valid,
  output logic [IDX_WIDTH-1:0]        grant_index
);

  if (PORTS < 2 || PORTS > 8 || IDX_WIDTH < 1 || IDX_WIDTH < clog2(PORTS)) begin : g_bad_params
    $error("axis_frame_arbiter: PORTS must be 2..8 and IDX_WIDTH >= clog2(PORTS)");
  end

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both high. The sink's ready is routed only to the granted source, and the
  // granted source's valid only to the sink, so ungranted sources never move.
  arb_state_e           state_q;
  logic                 grant_valid_q;
  logic [IDX_WIDTH-1:0] grant_index_q;
  logic [IDX_WIDTH-1:0] ptr_q;

  logic                  rr_any;
  logic [IDX_WIDTH-1:0]  rr_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  sel_user;
  logic                  in_grant;
  logic                  beat_accept;

  axis_rr_select #(
    .PORTS     (PORTS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_select (
    .req (input_axis_tvalid),
    .ptr (ptr_q),
    .any (rr_any),
    .idx (rr_idx)
  );

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_index_q == IDX_WIDTH'(i)) begin
        sel_data  = input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = input_axis_tvalid[i];
        sel_last  = input_axis_tlast[i];
        sel_user  = input_axis_tuser[i];
      end
    end
  end

  // Outside GRANT every output is forced to zero, which also covers reset.
  always_comb begin
    in_grant           = (state_q == ST_GRANT);
    output_axis_tvalid = in_grant & sel_valid;
    output_axis_tdata  = in_grant ? sel_data : '0;
    output_axis_tlast  = in_grant & sel_last;
    output_axis_tuser  = in_grant & sel_user;
    beat_accept        = output_axis_tvalid & output_axis_tready;
    input_axis_tready  = '0;
    for (int i = 0; i < PORTS; i++) begin
      input_axis_tready[i] = in_grant & (grant_index_q == IDX_WIDTH'(i)) & output_axis_tready;
    end
  end

  // ptr resets to the last port so port 0 wins the first arbitration.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      ptr_q         <= IDX_WIDTH'(PORTS - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rr_any) begin
            grant_index_q <= rr_idx;
            grant_valid_q <= 1'b1;
            state_q       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (beat_accept && sel_last) begin
            ptr_q         <= grant_index_q;
            grant_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_index = grant_index_q;

endmodule
